// File: rtl/data_mem_responder.sv
// data_mem_responder: single-cycle data-memory responder (word RAM + LED/switch/counter/compare/status MMIO page; CPU bus iAB/iWriteData/iWR/oReadData, board iSwitch/oLED, flags oIRQ/oErr)
module data_mem_responder #(
  parameter int DATAWIDTH = 32,
  parameter int ADDRWIDTH = 32,
  parameter int RAM_WORDS = 256,
  parameter logic [ADDRWIDTH-1:0] MMIO_BASE = 32'h0000_F000
) (
  input  logic                 iCPU_Clk,
  input  logic                 iCPU_Reset_n,
  input  logic [ADDRWIDTH-1:0] iAB,
  input  logic [DATAWIDTH-1:0] iWriteData,
  input  logic                 iWR,
  output logic [DATAWIDTH-1:0] oReadData,
  input  logic [15:0]          iSwitch,
  output logic [15:0]          oLED,
  output logic                 oIRQ,
  output logic                 oErr
);
  localparam int RAM_AW = $clog2(RAM_WORDS);
  localparam int WW = ADDRWIDTH - 2;
  localparam logic [ADDRWIDTH-1:0] RAM_BYTES = ADDRWIDTH'(RAM_WORDS * 4);
  localparam logic [WW-1:0] MMIO_WORD = MMIO_BASE[ADDRWIDTH-1:2];
  logic [DATAWIDTH-1:0] mem [RAM_WORDS];
  logic [WW-1:0] off;
  logic sel_ram, sel_led, sel_sw, sel_cnt, sel_cmp, sel_st;
  logic wr_ok, misalign_wr, match;
  logic [1:0] clr;
  logic [15:0] led, sw_meta, sw_sync;
  logic [DATAWIDTH-1:0] counter, compare;
  logic [1:0] status;
  assign off = iAB[ADDRWIDTH-1:2] - MMIO_WORD;
  assign sel_ram = iAB < RAM_BYTES;
  assign sel_led = !sel_ram && off == WW'(0);
  assign sel_sw = !sel_ram && off == WW'(1);
  assign sel_cnt = !sel_ram && off == WW'(2);
  assign sel_cmp = !sel_ram && off == WW'(3);
  assign sel_st = !sel_ram && off == WW'(4);
  assign wr_ok = iWR && iAB[1:0] == 2'b00;
  assign misalign_wr = iWR && iAB[1:0] != 2'b00;
  assign match = counter == compare;
  assign clr = (wr_ok && sel_st) ? iWriteData[1:0] : 2'b00;
  always_ff @(posedge iCPU_Clk)
    if (wr_ok && sel_ram) mem[iAB[RAM_AW+1:2]] <= iWriteData;
  always_ff @(posedge iCPU_Clk or negedge iCPU_Reset_n)
    if (!iCPU_Reset_n) begin
      led <= '0;
      sw_meta <= '0;
      sw_sync <= '0;
      counter <= '0;
      compare <= '1;
      status <= '0;
    end else begin
      sw_meta <= iSwitch;
      sw_sync <= sw_meta;
      if (wr_ok && sel_led) led <= iWriteData[15:0];
      if (wr_ok && sel_cmp) compare <= iWriteData;
      counter <= (wr_ok && sel_cnt) ? iWriteData : counter + 1'b1;
      status <= {misalign_wr | (status[1] & ~clr[1]), match | (status[0] & ~clr[0])};
    end
  always_comb
    oReadData = sel_ram ? mem[iAB[RAM_AW+1:2]]
              : sel_led ? {{(DATAWIDTH-16){1'b0}}, led}
              : sel_sw  ? {{(DATAWIDTH-16){1'b0}}, sw_sync}
              : sel_cnt ? counter
              : sel_cmp ? compare
              : sel_st  ? {{(DATAWIDTH-2){1'b0}}, status}
              : '0;
  assign oLED = led;
  assign oIRQ = status[0];
  assign oErr = status[1];
endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: directed self-checking bench for data_mem_responder
module tb_data_mem_responder;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [31:0] ab = '0;
  logic [31:0] wd = '0;
  logic wr = 1'b0;
  logic [31:0] rdata;
  logic [15:0] sw = '0;
  logic [15:0] led;
  logic irq, err;
  logic [31:0] v;
  int checks = 0;
  int failures = 0;
  data_mem_responder dut (
    .iCPU_Clk(clk), .iCPU_Reset_n(rst_n), .iAB(ab), .iWriteData(wd), .iWR(wr),
    .oReadData(rdata), .iSwitch(sw), .oLED(led), .oIRQ(irq), .oErr(err)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic write(input logic [31:0] a, input logic [31:0] d);
    ab = a;
    wd = d;
    wr = 1'b1;
    tick();
    wr = 1'b0;
  endtask
  task automatic read(input logic [31:0] a, output logic [31:0] d);
    ab = a;
    #1;
    d = rdata;
  endtask
  initial begin
    #100000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end
  initial begin
    #12;
    check("rst_led", {16'h0, led}, 32'h0);
    check("rst_irq", {31'h0, irq}, 32'h0);
    check("rst_err", {31'h0, err}, 32'h0);
    read(32'hF008, v); check("rst_cnt", v, 32'h0);
    read(32'hF00C, v); check("rst_cmp", v, 32'hFFFF_FFFF);
    read(32'hF010, v); check("rst_status", v, 32'h0);
    @(negedge clk) rst_n = 1'b1;
    tick();
    write(32'h10, 32'h1111_1111);
    ab = 32'h10; wd = 32'hDEAD_BEEF; wr = 1'b1;
    #1 check("ram_old_during_wr", rdata, 32'h1111_1111);
    tick();
    wr = 1'b0;
    read(32'h10, v); check("ram_rd", v, 32'hDEAD_BEEF);
    sw = 16'hA5A5;
    read(32'hF004, v); check("sw_edge0", v, 32'h0);
    tick(); read(32'hF004, v); check("sw_edge1", v, 32'h0);
    tick(); read(32'hF004, v); check("sw_edge2", v, 32'h0000_A5A5);
    write(32'hF000, 32'h1234_ABCD);
    check("led_out", {16'h0, led}, 32'h0000_ABCD);
    read(32'hF000, v); check("led_rd", v, 32'h0000_ABCD);
    read(32'h8000, v); check("unmapped_rd", v, 32'h0);
    write(32'h8000, 32'hFFFF_FFFF);
    check("unmapped_wr_no_err", {31'h0, err}, 32'h0);
    write(32'h12, 32'h1234_5678);
    read(32'h10, v); check("misalign_ram_kept", v, 32'hDEAD_BEEF);
    check("misalign_err", {31'h0, err}, 32'h1);
    read(32'h12, v); check("misalign_rd_aligned", v, 32'hDEAD_BEEF);
    write(32'hF010, 32'h2);
    check("err_w1c", {31'h0, err}, 32'h0);
    write(32'hF008, 32'd100);
    write(32'hF00C, 32'd20);
    write(32'hF008, 32'd10);
    check("timer_pre_irq", {31'h0, irq}, 32'h0);
    for (int i = 0; i < 10; i++) tick();
    check("timer_no_irq_yet", {31'h0, irq}, 32'h0);
    read(32'hF008, v); check("timer_cnt20", v, 32'd20);
    tick();
    check("timer_irq", {31'h0, irq}, 32'h1);
    read(32'hF008, v); check("timer_cnt21", v, 32'd21);
    write(32'hF010, 32'h1);
    check("irq_w1c", {31'h0, irq}, 32'h0);
    write(32'hF008, 32'd19);
    tick();
    check("pre_clr_match_irq", {31'h0, irq}, 32'h0);
    write(32'hF010, 32'h1);
    check("set_beats_clr", {31'h0, irq}, 32'h1);
    write(32'hF010, 32'h1);
    write(32'hF008, 32'hFFFF_FFFE);
    read(32'hF008, v); check("cnt_load", v, 32'hFFFF_FFFE);
    tick(); read(32'hF008, v); check("cnt_ffff", v, 32'hFFFF_FFFF);
    tick(); read(32'hF008, v); check("cnt_wrap", v, 32'h0);
    write(32'hF008, 32'd5);
    read(32'hF008, v); check("cnt_load5", v, 32'd5);
    tick(); read(32'hF008, v); check("cnt_6", v, 32'd6);
    write(32'hF000, 32'h0000_FFFF);
    write(32'hF008, 32'd19);
    tick(); tick();
    check("pre_rst_led", {16'h0, led}, 32'h0000_FFFF);
    check("pre_rst_irq", {31'h0, irq}, 32'h1);
    #2 rst_n = 1'b0;
    #1;
    check("async_led", {16'h0, led}, 32'h0);
    check("async_irq", {31'h0, irq}, 32'h0);
    read(32'hF008, v); check("async_cnt", v, 32'h0);
    read(32'hF00C, v); check("async_cmp", v, 32'hFFFF_FFFF);
    @(negedge clk) rst_n = 1'b1;
    tick();
    read(32'h10, v); check("ram_after_rst", v, 32'hDEAD_BEEF);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
